// File: rtl/sram_bus_arbiter.sv
// Purpose : shares one SRAM controller port between M0 (data) and M1 (fetch).
//           M0 has fixed priority. M1 is forced in after STARVE_LIMIT back-to-back M0 grants.
// Latency : grant at the request edge, then ack/err on the edge that sees ready or the timeout.
//           Each access ends with one DONE cycle in which ce is low.
// Backpr. : a master holds mX_ce_i until it sees mX_ack_o or mX_err_o.
//           An access that never gets sram_ready_i is aborted after TIMEOUT cycles.
// Ports   : clk/rst (async, active-high); m0_*/m1_* master ports (ce, we, addr, data, sel in;
//           data, ack, err out); sram_* controller port; grant_o one-hot debug owner.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_ce_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_ce_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        sram_ce_o,
    output logic        sram_we_o,
    output logic [31:0] sram_addr_o,
    output logic [31:0] sram_data_o,
    output logic [3:0]  sram_sel_o,
    input  logic        sram_ready_i,
    input  logic [31:0] sram_data_i,
    output logic [1:0]  grant_o
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        sram_ce_q, sram_ce_d;
    logic        sram_we_q, sram_we_d;
    logic [31:0] sram_addr_q, sram_addr_d;
    logic [31:0] sram_data_q, sram_data_d;
    logic [3:0]  sram_sel_q, sram_sel_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] m0_data_q, m0_data_d;
    logic [31:0] m1_data_q, m1_data_d;
    logic        m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic        m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
    logic        pick_m0, pick_m1, finish;

    // M1 wins either because M0 is absent or because M0 has used up its run.
    assign pick_m1 = m1_ce_i && ((starve_q == STARVE_MAX) || !m0_ce_i);
    assign pick_m0 = m0_ce_i && !pick_m1;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        sram_ce_d   = sram_ce_q;
        sram_we_d   = sram_we_q;
        sram_addr_d = sram_addr_q;
        sram_data_d = sram_data_q;
        sram_sel_d  = sram_sel_q;
        grant_d     = grant_q;
        m0_data_d   = m0_data_q;
        m1_data_d   = m1_data_q;
        m0_ack_d    = 1'b0;
        m0_err_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m1_err_d    = 1'b0;
        finish      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_m0 || pick_m1) begin
                    sram_ce_d   = 1'b1;
                    sram_we_d   = pick_m1 ? m1_we_i   : m0_we_i;
                    sram_addr_d = pick_m1 ? m1_addr_i : m0_addr_i;
                    sram_data_d = pick_m1 ? m1_data_i : m0_data_i;
                    sram_sel_d  = pick_m1 ? m1_sel_i  : m0_sel_i;
                    grant_d     = pick_m1 ? 2'b10 : 2'b01;
                    tmo_d       = 8'd0;
                    state_d     = S_BUSY;
                    if (pick_m1 || !m1_ce_i) begin
                        starve_d = 4'd0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            S_BUSY: begin
                // Ready is checked first so a ready on the last timeout cycle still acks.
                if (sram_ready_i) begin
                    if (grant_q[1]) begin
                        m1_data_d = sram_data_i;
                        m1_ack_d  = 1'b1;
                    end else begin
                        m0_data_d = sram_data_i;
                        m0_ack_d  = 1'b1;
                    end
                    finish = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    m1_err_d = grant_q[1];
                    m0_err_d = grant_q[0];
                    finish   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The bus returns to all-zero during the DONE cycle.
        if (finish) begin
            sram_ce_d   = 1'b0;
            sram_we_d   = 1'b0;
            sram_addr_d = 32'd0;
            sram_data_d = 32'd0;
            sram_sel_d  = 4'd0;
            grant_d     = 2'b00;
            state_d     = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            starve_q    <= 4'd0;
            tmo_q       <= 8'd0;
            sram_ce_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= 32'd0;
            sram_data_q <= 32'd0;
            sram_sel_q  <= 4'd0;
            grant_q     <= 2'b00;
            m0_data_q   <= 32'd0;
            m1_data_q   <= 32'd0;
            m0_ack_q    <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            sram_ce_q   <= sram_ce_d;
            sram_we_q   <= sram_we_d;
            sram_addr_q <= sram_addr_d;
            sram_data_q <= sram_data_d;
            sram_sel_q  <= sram_sel_d;
            grant_q     <= grant_d;
            m0_data_q   <= m0_data_d;
            m1_data_q   <= m1_data_d;
            m0_ack_q    <= m0_ack_d;
            m0_err_q    <= m0_err_d;
            m1_ack_q    <= m1_ack_d;
            m1_err_q    <= m1_err_d;
        end
    end

    assign sram_ce_o   = sram_ce_q;
    assign sram_we_o   = sram_we_q;
    assign sram_addr_o = sram_addr_q;
    assign sram_data_o = sram_data_q;
    assign sram_sel_o  = sram_sel_q;
    assign grant_o     = grant_q;
    assign m0_data_o   = m0_data_q;
    assign m0_ack_o    = m0_ack_q;
    assign m0_err_o    = m0_err_q;
    assign m1_data_o   = m1_data_q;
    assign m1_ack_o    = m1_ack_q;
    assign m1_err_o    = m1_err_q;

endmodule
